// File: rtl/hk_spi_pkg.sv
// Shared constants and state type for the housekeeping SPI responder.
package hk_spi_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_READ  = 8'h40;
    localparam logic [7:0] CMD_RDWR  = 8'hC0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } spi_state_e;

endpackage

// File: rtl/hk_spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall
// detection taken from the last two synchronized samples.
module hk_spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic resetb,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/hk_spi_responder.sv
// SPI mode-0 responder that turns CMD/ADDR/DATA byte streams into
// one-cycle register read and write strobes, with auto-incrementing address.
//
// state  | meaning
// IDLE   | CSB high or not yet armed; waiting for a CSB fall
// CMD    | shifting in the command byte
// ADDR   | shifting in the start address
// DATA   | streaming data bytes (read, write or both)
// IGNORE | unknown command; wait for CSB high
module hk_spi_responder
    import hk_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       spi_csb,
    input  logic       spi_sck,
    input  logic       spi_sdi,
    output logic       spi_sdo,
    output logic       spi_sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    localparam logic [2:0] START_CNT = 3'(SYNC_STAGES + 1);

    spi_state_e state, state_nxt;

    logic       csb_s, csb_fall, unused_csb_rise;
    logic       sck_rise, sck_fall, unused_sck_s;
    logic       sdi_s, unused_sdi_rise, unused_sdi_fall;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       rd_mode, wr_mode;
    logic       rd_pend, inc_pend;
    logic       sdo_q;
    logic [2:0] startup_cnt;
    logic       armed;

    hk_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
        .clock(clock), .resetb(resetb), .din(spi_csb),
        .sync(csb_s), .rise(unused_csb_rise), .fall(csb_fall)
    );

    hk_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clock(clock), .resetb(resetb), .din(spi_sck),
        .sync(unused_sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    hk_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clock(clock), .resetb(resetb), .din(spi_sdi),
        .sync(sdi_s), .rise(unused_sdi_rise), .fall(unused_sdi_fall)
    );

    assign rx_byte   = {rx_shift[6:0], sdi_s};
    assign byte_done = sck_rise && !csb_s && (bit_cnt == 3'd7);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (csb_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (csb_fall && armed) state_nxt = CMD;
                CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_WRITE || rx_byte == CMD_READ || rx_byte == CMD_RDWR)
                            state_nxt = ADDR;
                        else
                            state_nxt = IGNORE;
                    end
                end
                ADDR:    if (byte_done) state_nxt = DATA;
                DATA:    state_nxt = DATA;
                IGNORE:  state_nxt = IGNORE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            reg_addr    <= 8'h00;
            reg_wdata   <= 8'h00;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            rd_mode     <= 1'b0;
            wr_mode     <= 1'b0;
            rd_pend     <= 1'b0;
            inc_pend    <= 1'b0;
            sdo_q       <= 1'b0;
            startup_cnt <= START_CNT;
            armed       <= 1'b0;
        end else begin
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            inc_pend <= 1'b0;
            rd_pend  <= reg_re;

            // Only trust CSB high once the synchronizer holds real samples,
            // so a transfer already in progress at reset release is skipped.
            if (startup_cnt != 3'd0) startup_cnt <= startup_cnt - 3'd1;
            else if (csb_s)          armed       <= 1'b1;

            if (state == IDLE) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte;
            end

            if (byte_done) begin
                case (state)
                    CMD: begin
                        rd_mode <= (rx_byte == CMD_READ)  || (rx_byte == CMD_RDWR);
                        wr_mode <= (rx_byte == CMD_WRITE) || (rx_byte == CMD_RDWR);
                    end
                    ADDR: begin
                        reg_addr <= rx_byte;
                        reg_re   <= rd_mode;
                    end
                    DATA: begin
                        if (wr_mode) begin
                            reg_we    <= 1'b1;
                            reg_wdata <= rx_byte;
                        end
                        inc_pend <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // Increment one cycle after the write so the write sees the old address.
            if (inc_pend && state == DATA) begin
                reg_addr <= reg_addr + 8'd1;
                reg_re   <= rd_mode;
            end

            if (rd_pend) begin
                tx_shift <= reg_rdata;
            end else if (state == DATA && rd_mode && sck_fall) begin
                sdo_q    <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            if (state != DATA) sdo_q <= 1'b0;
        end
    end

    assign spi_sdo_oe = (state == DATA) && rd_mode;
    assign spi_sdo    = spi_sdo_oe & sdo_q;

endmodule

// File: tb/tb_hk_spi_responder.sv
// Self-checking bench for hk_spi_responder: SPI master tasks, register-file
// model and a strobe scoreboard.
`timescale 1ns/1ps
module tb_hk_spi_responder;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clock = 1'b0;
    logic       resetb = 1'b0;
    logic       spi_csb = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_sdi = 1'b0;
    logic       spi_sdo, spi_sdo_oe;
    logic [7:0] reg_addr, reg_wdata;
    logic       reg_we, reg_re;
    logic [7:0] reg_rdata = 8'h00;

    int   errors = 0;
    int   checks = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;
    logic [7:0] mem [256];
    logic oe_seen = 1'b0;
    logic sdo_leak = 1'b0;
    int   strobe_cnt = 0;

    hk_spi_responder #(.SYNC_STAGES(2)) dut (
        .clock(clock), .resetb(resetb),
        .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata)
    );

    always #12.5 clock = ~clock;

    // Register-file model: read data appears the cycle after reg_re.
    always @(posedge clock) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    always @(negedge clock) begin
        if (resetb) begin
            if (spi_sdo_oe) oe_seen = 1'b1;
            if (!spi_sdo_oe && spi_sdo) sdo_leak = 1'b1;
            if (reg_we || reg_re) strobe_cnt++;
            if (reg_we && reg_re) begin
                checks++; errors++;
                $display("FAIL strobe_overlap: we=1 re=1 at addr %02h, required never both", reg_addr);
            end else if (reg_we || reg_re) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: we=%0b re=%0b addr=%02h wdata=%02h, required none",
                             reg_we, reg_re, reg_addr, reg_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.we !== reg_we || mon_e.addr !== reg_addr ||
                        (reg_we && mon_e.data !== reg_wdata)) begin
                        errors++;
                        $display("FAIL strobe: got we=%0b addr=%02h wdata=%02h, required we=%0b addr=%02h wdata=%02h",
                                 reg_we, reg_addr, reg_wdata, mon_e.we, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic push_ev(input logic we, input logic [7:0] addr, input logic [7:0] data);
        ev_t e;
        e.we = we; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic spi_start();
        spi_csb = 1'b0;
        #100;
    endtask

    task automatic spi_stop();
        spi_sck = 1'b0;
        spi_sdi = 1'b0;
        #100;
        spi_csb = 1'b1;
        #400;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            spi_sck = 1'b0;
            spi_sdi = b[i];
            #100;
            spi_sck = 1'b1;
            r[i] = spi_sdo;
            #100;
        end
    endtask

    task automatic test_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d strobes missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [7:0] got [6];
        got[0] = 8'(spi_sdo); got[1] = 8'(spi_sdo_oe); got[2] = reg_addr;
        got[3] = reg_wdata;   got[4] = 8'(reg_we);     got[5] = 8'(reg_re);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== 8'h00) begin
                errors++;
                $display("FAIL %s_out%0d: got %02h, required 00", name, i, got[i]);
            end
        end
    endtask

    task automatic test_reset();
        #50;
        check_reset_outputs("reset");
        #56;
        resetb = 1'b1;
        #200;
    endtask

    task automatic test_read_single();
        logic [7:0] r;
        oe_seen = 1'b0;
        push_ev(1'b0, 8'h03, 8'h00);
        push_ev(1'b0, 8'h04, 8'h00);
        spi_start();
        spi_byte(8'h40, r);
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_stop();
        checks++;
        if (r !== 8'h11) begin
            errors++; $display("FAIL read_single_sdo: got %02h, required 11", r);
        end
        checks++;
        if (oe_seen !== 1'b1) begin
            errors++; $display("FAIL read_single_oe: got %0b, required 1", oe_seen);
        end
        test_queue_empty("read_single");
    endtask

    task automatic test_write_single();
        logic [7:0] r;
        oe_seen = 1'b0;
        push_ev(1'b1, 8'h0B, 8'h01);
        spi_start();
        spi_byte(8'h80, r);
        spi_byte(8'h0B, r);
        spi_byte(8'h01, r);
        spi_stop();
        test_queue_empty("write_single");
        checks++;
        if (oe_seen !== 1'b0) begin
            errors++; $display("FAIL write_single_oe: got %0b, required 0", oe_seen);
        end
    endtask

    task automatic test_read_burst();
        logic [7:0] r;
        logic [7:0] exp_sdo [19];
        for (int i = 0; i < 19; i++) exp_sdo[i] = mem[i];
        for (int i = 0; i <= 19; i++) push_ev(1'b0, 8'(i), 8'h00);
        spi_start();
        spi_byte(8'h40, r);
        spi_byte(8'h00, r);
        for (int i = 0; i < 19; i++) begin
            spi_byte(8'h00, r);
            checks++;
            if (r !== exp_sdo[i]) begin
                errors++;
                $display("FAIL burst_sdo[%0d]: got %02h, required %02h", i, r, exp_sdo[i]);
            end
        end
        spi_stop();
        test_queue_empty("read_burst");
    endtask

    task automatic test_rdwr_wrap();
        logic [7:0] r0, r1, old_ff, old_00;
        old_ff = mem[8'hFF];
        old_00 = mem[8'h00];
        push_ev(1'b0, 8'hFF, 8'h00);
        push_ev(1'b1, 8'hFF, 8'hAA);
        push_ev(1'b0, 8'h00, 8'h00);
        push_ev(1'b1, 8'h00, 8'h55);
        push_ev(1'b0, 8'h01, 8'h00);
        spi_start();
        spi_byte(8'hC0, r0);
        spi_byte(8'hFF, r0);
        spi_byte(8'hAA, r0);
        spi_byte(8'h55, r1);
        spi_stop();
        checks++;
        if (r0 !== old_ff) begin
            errors++; $display("FAIL rdwr_sdo0: got %02h, required %02h", r0, old_ff);
        end
        checks++;
        if (r1 !== old_00) begin
            errors++; $display("FAIL rdwr_sdo1: got %02h, required %02h", r1, old_00);
        end
        checks++;
        if (mem[8'hFF] !== 8'hAA || mem[8'h00] !== 8'h55) begin
            errors++;
            $display("FAIL rdwr_mem: got ff=%02h 00=%02h, required ff=aa 00=55", mem[8'hFF], mem[8'h00]);
        end
        test_queue_empty("rdwr_wrap");
    endtask

    task automatic test_partial_byte();
        logic [7:0] r;
        spi_start();
        spi_byte(8'h80, r);
        spi_byte(8'h05, r);
        for (int i = 0; i < 5; i++) begin
            spi_sck = 1'b0; spi_sdi = 1'b1; #100;
            spi_sck = 1'b1; #100;
        end
        spi_stop();
        test_queue_empty("partial");
        push_ev(1'b1, 8'h07, 8'h3C);
        spi_start();
        spi_byte(8'h80, r);
        spi_byte(8'h07, r);
        spi_byte(8'h3C, r);
        spi_stop();
        test_queue_empty("after_partial");
        checks++;
        if (mem[8'h05] === 8'hF8 || mem[8'h07] !== 8'h3C) begin
            errors++;
            $display("FAIL partial_mem: got 05=%02h 07=%02h, required 07=3c and 05 untouched", mem[8'h05], mem[8'h07]);
        end
    endtask

    task automatic test_ignore();
        logic [7:0] r;
        int s0;
        oe_seen = 1'b0;
        s0 = strobe_cnt;
        spi_start();
        spi_byte(8'h00, r);
        spi_byte(8'hA5, r);
        spi_byte(8'h40, r);
        spi_byte(8'h12, r);
        spi_stop();
        checks++;
        if (strobe_cnt != s0) begin
            errors++; $display("FAIL ignore_strobes: got %0d, required 0", strobe_cnt - s0);
        end
        checks++;
        if (oe_seen !== 1'b0) begin
            errors++; $display("FAIL ignore_oe: got %0b, required 0", oe_seen);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] r;
        logic [7:0] exp20;
        push_ev(1'b0, 8'h10, 8'h00);
        push_ev(1'b0, 8'h11, 8'h00);
        fork
            begin
                spi_start();
                spi_byte(8'h40, r);
                spi_byte(8'h10, r);
                spi_byte(8'h00, r);
                spi_byte(8'h00, r);
                spi_byte(8'h00, r);
                spi_stop();
            end
            begin
                #5500;
                checks++;
                if (spi_sdo_oe !== 1'b1) begin
                    errors++; $display("FAIL midreset_pre_oe: got %0b, required 1", spi_sdo_oe);
                end
                resetb = 1'b0;
                #1;
                check_reset_outputs("midreset");
                #299;
                resetb = 1'b1;
            end
        join
        test_queue_empty("midreset");
        exp20 = mem[8'h20];
        push_ev(1'b0, 8'h20, 8'h00);
        push_ev(1'b0, 8'h21, 8'h00);
        spi_start();
        spi_byte(8'h40, r);
        spi_byte(8'h20, r);
        spi_byte(8'h00, r);
        spi_stop();
        checks++;
        if (r !== exp20) begin
            errors++; $display("FAIL post_reset_sdo: got %02h, required %02h", r, exp20);
        end
        test_queue_empty("post_reset");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[0] = 8'h00; mem[1] = 8'h04; mem[2] = 8'h56; mem[3] = 8'h11;
        for (int i = 4; i < 18; i++) mem[i] = 8'(i * 29 + 3);
        mem[18] = 8'h04;

        test_reset();
        test_read_single();
        test_write_single();
        test_read_burst();
        test_rdwr_wrap();
        test_partial_byte();
        test_ignore();
        test_reset_mid_read();

        checks++;
        if (sdo_leak !== 1'b0) begin
            errors++; $display("FAIL sdo_without_oe: got %0b, required 0", sdo_leak);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
